// File: rtl/ov7670_pkg.sv
// Shared constants, state encoding and default register table for the OV7670 SCCB configurator.
package ov7670_pkg;

  localparam int unsigned ENTRY_W       = 16;
  localparam logic [15:0] REG_END       = 16'hFFFF;
  localparam logic [15:0] REG_DELAY     = 16'hFFF0;
  localparam logic [7:0]  SCCB_DEV_ADDR = 8'h42;
  localparam logic [4:0]  LAST_BIT      = 5'd26;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } sccb_state_e;

  // Entry 0 sits in the low 16 bits; soft reset first, then the settle delay.
  localparam logic [ENTRY_W*64-1:0] DEFAULT_TABLE = {
    {54{16'hFFFF}},
    16'h1438, 16'h3A04, 16'h8C00, 16'h40D0, 16'h3E00,
    16'h0C00, 16'h1204, 16'h1101, 16'hFFF0, 16'h1280
  };

  // The ninth bit of each SCCB byte phase is the don't-care/ACK slot.
  function automatic logic is_ack_bit(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Register table ROM: {reg, val} entries with a registered read port (1 clk latency).
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int unsigned ROM_AW = 6,
  parameter logic [ENTRY_W*(2**ROM_AW)-1:0] ROM_INIT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  localparam int unsigned DEPTH = 2**ROM_AW;

  logic [15:0] table_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign table_w[i] = ROM_INIT[ENTRY_W*i +: ENTRY_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data <= REG_END;
    else      data <= table_w[addr];
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Power-up OV7670 programmer: walks the register table and issues 3-phase SCCB writes.
//
// state  | meaning
// IDLE   | lines idle, waiting for start
// FETCH  | table address presented, ROM read in flight
// DECODE | classify entry: END, DELAY or write (write waits for quarter tick)
// START  | SCCB start condition, 2 quarters
// BITS   | 27 bits (3 bytes + don't-care slots), 4 quarters each
// STOP   | SCCB stop condition, 4 quarters
// GAP    | 4 idle quarters between writes
// WAIT   | settle delay for a DELAY marker
// DONE   | walk finished, raise done
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 125_000_000,
  parameter int unsigned SCCB_HZ  = 100_000,
  parameter logic [7:0]  DEV_ADDR = SCCB_DEV_ADDR,
  parameter int unsigned DELAY_MS = 10,
  parameter int unsigned ROM_AW   = 6,
  parameter logic [ENTRY_W*(2**ROM_AW)-1:0] ROM_INIT = DEFAULT_TABLE[ENTRY_W*(2**ROM_AW)-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              siod_in,
  output logic              sioc,
  output logic              siod_oe,
  output logic              busy,
  output logic              done,
  output logic              nack_seen,
  output logic [ROM_AW-1:0] reg_index
);

  localparam int unsigned     QDIV      = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned     QW        = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam longint unsigned DELAY_CLK = (longint'(DELAY_MS) * CLK_HZ) / 1000;
  localparam int unsigned     DW        = $clog2(DELAY_CLK + 1);

  sccb_state_e       state, state_nxt;
  logic [QW-1:0]     qcnt;
  logic              tick;
  logic [1:0]        q, q_nxt;
  logic [4:0]        bit_idx, bit_nxt;
  logic [23:0]       shreg, shreg_nxt;
  logic [DW-1:0]     dcnt, dcnt_nxt;
  logic [ROM_AW-1:0] idx_nxt;
  logic              busy_nxt, done_nxt, nack_nxt;
  logic              ack_bit;
  logic [15:0]       rom_data;

  ov7670_reg_rom #(
    .ROM_AW   (ROM_AW),
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (reg_index),
    .data (rom_data)
  );

  // Free-running quarter-bit timebase; every bus line change is aligned to it.
  assign tick = (qcnt == QW'(QDIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      qcnt <= '0;
    else if (tick) qcnt <= '0;
    else           qcnt <= qcnt + QW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      q         <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      dcnt      <= '0;
      reg_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      q         <= q_nxt;
      bit_idx   <= bit_nxt;
      shreg     <= shreg_nxt;
      dcnt      <= dcnt_nxt;
      reg_index <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      nack_seen <= nack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    dcnt_nxt  = dcnt;
    idx_nxt   = reg_index;
    busy_nxt  = busy;
    done_nxt  = done;
    nack_nxt  = nack_seen;
    sioc      = 1'b1;
    siod_oe   = 1'b0;
    ack_bit   = is_ack_bit(bit_idx);

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          idx_nxt   = '0;
          done_nxt  = 1'b0;
          nack_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (rom_data == REG_END) begin
          state_nxt = ST_DONE;
        end else if (rom_data == REG_DELAY) begin
          dcnt_nxt  = DW'(DELAY_CLK - 1);
          state_nxt = ST_WAIT;
        end else if (tick) begin
          shreg_nxt = {DEV_ADDR & 8'hFE, rom_data};
          bit_nxt   = '0;
          q_nxt     = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        sioc    = (q == 2'd0);
        siod_oe = 1'b1;
        if (tick) begin
          q_nxt = q + 2'd1;
          if (q == 2'd1) begin
            q_nxt     = '0;
            state_nxt = ST_BITS;
          end
        end
      end
      ST_BITS: begin
        sioc    = q[1];
        siod_oe = ack_bit ? 1'b0 : ~shreg[23];
        if (tick) begin
          q_nxt = q + 2'd1;
          if (q == 2'd2 && ack_bit && siod_in) nack_nxt = 1'b1;
          if (q == 2'd3) begin
            if (!ack_bit) shreg_nxt = {shreg[22:0], 1'b0};
            if (bit_idx == LAST_BIT) begin
              bit_nxt   = '0;
              state_nxt = ST_STOP;
            end else begin
              bit_nxt = bit_idx + 5'd1;
            end
          end
        end
      end
      ST_STOP: begin
        sioc    = (q != 2'd0);
        siod_oe = ~q[1];
        if (tick) begin
          q_nxt = q + 2'd1;
          if (q == 2'd3) state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          q_nxt = q + 2'd1;
          if (q == 2'd3) begin
            if (&reg_index) state_nxt = ST_DONE;
            else begin
              idx_nxt   = reg_index + ROM_AW'(1);
              state_nxt = ST_FETCH;
            end
          end
        end
      end
      ST_WAIT: begin
        if (dcnt == '0) begin
          // Last entry may be a delay marker: finish rather than wrap the index.
          if (&reg_index) state_nxt = ST_DONE;
          else begin
            idx_nxt   = reg_index + ROM_AW'(1);
            state_nxt = ST_FETCH;
          end
        end else begin
          dcnt_nxt = dcnt - DW'(1);
        end
      end
      ST_DONE: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench: decodes the SCCB bus of two configurator instances and checks against a table-walk model.
module tb_ov7670_sccb_config;

  localparam int DLY = 4;
  localparam logic [63:0]  TAB_A = {16'hFFFF, 16'h1101, 16'hFFF0, 16'h1280};
  localparam logic [127:0] TAB_B = {16'h3A04, 16'h40D0, 16'h8C00, 16'h1438,
                                    16'h0C00, 16'h3E00, 16'h1204, 16'h1101};

  logic clk, rst, start_a, start_b, siod_in;
  logic sioc_a, oe_a, busy_a, done_a, nack_a;
  logic sioc_b, oe_b, busy_b, done_b, nack_b;
  logic [1:0] idx_a;
  logic [2:0] idx_b;

  ov7670_sccb_config #(.CLK_HZ(400), .SCCB_HZ(100), .DEV_ADDR(8'h42), .DELAY_MS(10),
                       .ROM_AW(2), .ROM_INIT(TAB_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .siod_in(siod_in), .sioc(sioc_a),
    .siod_oe(oe_a), .busy(busy_a), .done(done_a), .nack_seen(nack_a), .reg_index(idx_a));

  ov7670_sccb_config #(.CLK_HZ(400), .SCCB_HZ(100), .DEV_ADDR(8'h42), .DELAY_MS(10),
                       .ROM_AW(3), .ROM_INIT(TAB_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .siod_in(siod_in), .sioc(sioc_b),
    .siod_oe(oe_b), .busy(busy_b), .done(done_b), .nack_seen(nack_b), .reg_index(idx_b));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int siod_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (siod_mode)
      0:       siod_in = 1'b0;
      1:       siod_in = 1'b1;
      default: siod_in = ($urandom_range(0, 63) == 0);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic        p_scl [2], p_sda [2], in_frame [2], nack_exp [2];
  int          nbits [2], last_stop [2];
  logic [26:0] sbits [2];
  logic [26:0] frm_a [$], frm_b [$];
  int          gap_a [$], gap_b [$];
  logic        c_scl, c_sda;

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      c_scl = (ch == 0) ? sioc_a : sioc_b;
      c_sda = (ch == 0) ? ~oe_a : ~oe_b;
      if (!rst) begin
        in_frame[ch] = 1'b0;
        p_scl[ch] = 1'b1;
        p_sda[ch] = 1'b1;
      end else begin
        if (p_scl[ch] && c_scl && p_sda[ch] && !c_sda) begin
          in_frame[ch] = 1'b1;
          nbits[ch] = 0;
          sbits[ch] = '0;
          if (last_stop[ch] >= 0) begin
            if (ch == 0) gap_a.push_back(cyc - last_stop[ch]);
            else         gap_b.push_back(cyc - last_stop[ch]);
          end
        end else if (p_scl[ch] && c_scl && !p_sda[ch] && c_sda) begin
          // 27 data clocks plus the clock rise that precedes the stop condition
          if (in_frame[ch]) begin
            if (ch == 0) frm_a.push_back((nbits[ch] == 28) ? sbits[ch] : 27'h0);
            else         frm_b.push_back((nbits[ch] == 28) ? sbits[ch] : 27'h0);
          end
          in_frame[ch] = 1'b0;
          last_stop[ch] = cyc;
        end else if (!p_scl[ch] && c_scl && in_frame[ch]) begin
          if (nbits[ch] == 8 || nbits[ch] == 17 || nbits[ch] == 26)
            nack_exp[ch] = nack_exp[ch] | siod_in;
          if (nbits[ch] < 27) sbits[ch] = {sbits[ch][25:0], c_sda};
          nbits[ch]++;
        end
        p_scl[ch] = c_scl;
        p_sda[ch] = c_sda;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [26:0] exp_frm [$];
  int          exp_gap [$];
  int          exp_lat, exp_idx;

  function automatic logic [15:0] entry(input int ch, input int i);
    if (ch == 0) return TAB_A[16*i +: 16];
    return TAB_B[16*i +: 16];
  endfunction

  task automatic model_walk(input int ch);
    int n, pend;
    bit ended, seen_write;
    logic [15:0] e;
    n = (ch == 0) ? 4 : 8;
    pend = 0; ended = 0; seen_write = 0;
    exp_frm.delete(); exp_gap.delete();
    exp_lat = 0; exp_idx = n - 1;
    for (int i = 0; i < n && !ended; i++) begin
      e = entry(ch, i);
      exp_lat += 2;                       // fetch + decode
      if (e == 16'hFFFF) begin
        ended = 1; exp_idx = i;
      end else if (e == 16'hFFF0) begin
        exp_lat += DLY; pend++;
      end else begin
        exp_lat += 118;                   // 2 start + 108 bits + 4 stop + 4 gap quarters
        exp_frm.push_back({8'h42, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1});
        if (seen_write) exp_gap.push_back(2 + 4 + 2 + pend * (2 + DLY));
        seen_write = 1; pend = 0;
      end
    end
    exp_lat += 1;                         // DONE state
  endtask

  function automatic logic dut_done(input int ch);
    return (ch == 0) ? done_a : done_b;
  endfunction

  function automatic int dut_idx(input int ch);
    return (ch == 0) ? int'(idx_a) : int'(idx_b);
  endfunction

  task automatic clear_mon(input int ch);
    if (ch == 0) begin frm_a.delete(); gap_a.delete(); end
    else begin frm_b.delete(); gap_b.delete(); end
    last_stop[ch] = -1;
    nack_exp[ch] = 1'b0;
  endtask

  task automatic pulse_start(input int ch, output int t0);
    @(negedge clk);
    if (ch == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic run_walk(input int ch, input bit mid_start, input int mode);
    int t0, k, lat, nf;
    bit got, left0, back0;
    siod_mode = (mode < 0) ? int'($urandom_range(0, 2)) : mode;
    clear_mon(ch);
    model_walk(ch);
    pulse_start(ch, t0);
    chk("done_clr", dut_done(ch), 1'b0);
    chk("busy_set", (ch == 0) ? busy_a : busy_b, 1'b1);
    k = mid_start ? int'($urandom_range(10, 230)) : -1;
    got = 0; lat = 0; left0 = 0; back0 = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (dut_idx(ch) != 0) left0 = 1;
      else if (left0) back0 = 1;
      if (dut_done(ch)) begin
        got = 1; lat = cyc - t0;
      end else begin
        if (ch == 0) start_a = (i == k); else start_b = (i == k);
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    chk("done_seen", got, 1'b1);
    chk("latency", lat, exp_lat);
    chk("idx_no_wrap", back0, 1'b0);
    repeat (20) @(negedge clk);
    chk("done_hold", dut_done(ch), 1'b1);
    chk("busy_end", (ch == 0) ? busy_a : busy_b, 1'b0);
    chk("idx_end", dut_idx(ch), exp_idx);
    chk("nack", (ch == 0) ? nack_a : nack_b, nack_exp[ch]);
    nf = (ch == 0) ? frm_a.size() : frm_b.size();
    chk("n_frames", nf, exp_frm.size());
    for (int i = 0; i < exp_frm.size(); i++)
      chk($sformatf("frame%0d", i),
          (i < nf) ? ((ch == 0) ? frm_a[i] : frm_b[i]) : 27'h0, exp_frm[i]);
    for (int i = 0; i < exp_gap.size(); i++)
      chk($sformatf("gap%0d", i),
          (ch == 0) ? ((i < gap_a.size()) ? gap_a[i] : -1)
                    : ((i < gap_b.size()) ? gap_b[i] : -1), exp_gap[i]);
  endtask

  task automatic reset_mid_walk();
    int t0, k;
    siod_mode = 0;
    clear_mon(0);
    pulse_start(0, t0);
    k = $urandom_range(40, 71);           // offsets inside the register-address byte
    repeat (k) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_sioc", sioc_a, 1'b1);
    chk("rst_oe", oe_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_idx", idx_a, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_frame", frm_a.size(), 0);
    chk("rst_lines_idle", {sioc_a, oe_a}, 2'b10);
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; siod_in = 1'b0;
    for (int ch = 0; ch < 2; ch++) clear_mon(ch);
    repeat (3) @(negedge clk);
    chk("r_sioc", sioc_a, 1'b1);
    chk("r_oe", oe_a, 1'b0);
    chk("r_busy", busy_a, 1'b0);
    chk("r_done", done_a, 1'b0);
    chk("r_nack", nack_a, 1'b0);
    chk("r_idx", idx_a, 2'd0);
    chk("r_b_lines", {sioc_b, oe_b, busy_b, done_b}, 4'b1000);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_walk(0, 0, 0);
    run_walk(0, 0, 1);
    run_walk(0, 1, -1);
    run_walk(0, $urandom_range(0, 1), 2);
    reset_mid_walk();
    run_walk(0, 0, -1);
    run_walk(1, 0, -1);
    run_walk(1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
